audio_filter_scheduler: RTL and testbench

Shares one multi-cycle filter engine (the start/done custom-instruction-style moving-average/convolution core) between NUM_CH audio channels.
- Each channel presents 16-bit samples through a valid/ready handshake into a one-entry holding register.
- A round-robin FSM issues one sample at a time to the engine with a channel tag, waits for done and returns the tagged result on a single output stream.
- A watchdog recovers from a hung engine.

---
 rtl/audio_sched_pkg.sv | 33 +++
 rtl/audio_filter_scheduler_rr_arbiter.sv | 34 +++
 rtl/audio_filter_scheduler.sv | 142 ++++++++++++++
 tb/tb_audio_filter_scheduler.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_sched_pkg.sv
// audio_sched_pkg: shared types and helpers for the audio filter scheduler.
// Rev 1.0
`default_nettype none

package audio_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    OUTPUT = 2'd3
  } sched_state_t;

  localparam int RES_W = 32;
  localparam int CNT_W = 10;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Replicates bit w-1 of a zero-extended sample into the upper bits.
  function automatic logic [RES_W-1:0] sext32(input logic [RES_W-1:0] s, input int w);
    logic [RES_W-1:0] r;
    r = s;
    for (int b = 0; b < RES_W; b++) begin
      if (b >= w) r[b] = s[w-1];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/audio_filter_scheduler_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority arbiter, search starts after last grant.
// Rev 1.0
`default_nettype none

module rr_arbiter
  import audio_sched_pkg::*;
#(
  parameter  int NUM_CH = 2,
  localparam int CH_W   = ch_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   last_i,
  output logic              any_grant_o,
  output logic [CH_W-1:0]   grant_o
);

  int idx;

  always_comb begin
    any_grant_o = 1'b0;
    grant_o     = '0;
    idx         = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_i) + k) % NUM_CH;
      if (!any_grant_o && req_i[idx]) begin
        any_grant_o = 1'b1;
        grant_o     = CH_W'(idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/audio_filter_scheduler.sv
// audio_filter_scheduler: round-robin sharing of one start/done filter engine across channels.
// Rev 1.0
`default_nettype none

module audio_filter_scheduler
  import audio_sched_pkg::*;
#(
  parameter  int NUM_CH  = 2,
  parameter  int DATA_W  = 16,
  parameter  int TIMEOUT = 255,
  localparam int CH_W    = ch_width(NUM_CH)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NUM_CH-1:0]        ch_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] ch_sample_i,
  output logic [NUM_CH-1:0]        ch_ready_o,
  output logic                     flt_start_o,
  output logic [CH_W-1:0]          flt_chan_o,
  output logic [RES_W-1:0]         flt_dataa_o,
  input  logic                     flt_done_i,
  input  logic [RES_W-1:0]         flt_result_i,
  output logic                     out_valid_o,
  output logic [CH_W-1:0]          out_chan_o,
  output logic [DATA_W-1:0]        out_sample_o,
  input  logic                     out_ready_i,
  output logic                     busy_o,
  output logic                     err_timeout_o
);

  sched_state_t      state_q;
  logic [NUM_CH-1:0] hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] hold_data_q [NUM_CH];
  logic [CH_W-1:0]   rr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              flt_start_q;
  logic [CH_W-1:0]   flt_chan_q;
  logic [RES_W-1:0]  flt_dataa_q;
  logic [CH_W-1:0]   out_chan_q;
  logic [DATA_W-1:0] out_sample_q;
  logic              err_q;
  logic              any_grant;
  logic [CH_W-1:0]   grant;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_arb (
    .req_i       (hold_valid_q),
    .last_i      (rr_q),
    .any_grant_o (any_grant),
    .grant_o     (grant)
  );

  // A slot is never refilled in the cycle it empties: ready is purely the registered state.
  always_comb begin
    hold_valid_d = hold_valid_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_valid_i[i] && !hold_valid_q[i]) hold_valid_d[i] = 1'b1;
    end
    if (state_q == ISSUE) hold_valid_d[flt_chan_q] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      hold_valid_q <= '0;
      for (int i = 0; i < NUM_CH; i++) hold_data_q[i] <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      for (int i = 0; i < NUM_CH; i++) begin
        if (ch_valid_i[i] && !hold_valid_q[i]) hold_data_q[i] <= ch_sample_i[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      rr_q         <= CH_W'(NUM_CH - 1);
      cnt_q        <= '0;
      flt_start_q  <= 1'b0;
      flt_chan_q   <= '0;
      flt_dataa_q  <= '0;
      out_chan_q   <= '0;
      out_sample_q <= '0;
      err_q        <= 1'b0;
    end else begin
      flt_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any_grant) begin
            flt_chan_q  <= grant;
            flt_dataa_q <= sext32(RES_W'(hold_data_q[grant]), DATA_W);
            rr_q        <= grant;
            flt_start_q <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (flt_done_i) begin
            out_sample_q <= flt_result_i[DATA_W-1:0];
            out_chan_q   <= flt_chan_q;
            state_q      <= OUTPUT;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            // Abandon the hung operation; the sample is lost.
            err_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        OUTPUT: begin
          if (out_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  generate
    if (DATA_W < RES_W) begin : g_unused_result
      logic unused_result_hi;
      assign unused_result_hi = ^flt_result_i[RES_W-1:DATA_W];
    end
  endgenerate

  assign ch_ready_o    = ~hold_valid_q;
  assign flt_start_o   = flt_start_q;
  assign flt_chan_o    = flt_chan_q;
  assign flt_dataa_o   = flt_dataa_q;
  assign out_valid_o   = (state_q == OUTPUT);
  assign out_chan_o    = out_chan_q;
  assign out_sample_o  = out_sample_q;
  assign busy_o        = (state_q != IDLE);
  assign err_timeout_o = err_q;

endmodule

`default_nettype wire

// File: tb/tb_audio_filter_scheduler.sv
// tb_audio_filter_scheduler: directed, table-driven check of the scheduler (NUM_CH=2, TIMEOUT=8).
// Rev 1.0
`default_nettype none

module tb_audio_filter_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  ch_valid;
  logic [31:0] ch_sample;
  logic [1:0]  ch_ready;
  logic        flt_start;
  logic [0:0]  flt_chan;
  logic [31:0] flt_dataa;
  logic        flt_done;
  logic [31:0] flt_result;
  logic        out_valid;
  logic [0:0]  out_chan;
  logic [15:0] out_sample;
  logic        out_ready;
  logic        busy;
  logic        err_timeout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  audio_filter_scheduler #(
    .NUM_CH  (2),
    .DATA_W  (16),
    .TIMEOUT (8)
  ) dut (
    .clk_i         (clk),
    .reset_i       (reset),
    .ch_valid_i    (ch_valid),
    .ch_sample_i   (ch_sample),
    .ch_ready_o    (ch_ready),
    .flt_start_o   (flt_start),
    .flt_chan_o    (flt_chan),
    .flt_dataa_o   (flt_dataa),
    .flt_done_i    (flt_done),
    .flt_result_i  (flt_result),
    .out_valid_o   (out_valid),
    .out_chan_o    (out_chan),
    .out_sample_o  (out_sample),
    .out_ready_i   (out_ready),
    .busy_o        (busy),
    .err_timeout_o (err_timeout)
  );

  typedef struct {
    int          chan;
    logic [15:0] sample;
    logic [31:0] result;
    int          dly;
    logic [31:0] exp_dataa;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vecs [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic offer(input int c, input logic [15:0] s);
    ch_valid[c]           = 1'b1;
    ch_sample[c*16 +: 16] = s;
    step();
    ch_valid[c] = 1'b0;
  endtask

  task automatic wait_start();
    for (int i = 0; i < 20 && !flt_start; i++) step();
    check("start_seen", {31'd0, flt_start}, 32'd1);
  endtask

  // Engine that echoes dataa two cycles after start; output accepted immediately.
  task automatic serve(input int ec, input logic [15:0] es);
    wait_start();
    check("srv_chan", {31'd0, flt_chan}, ec);
    check("srv_dataa", flt_dataa, {{16{es[15]}}, es});
    step();
    step();
    flt_done   = 1'b1;
    flt_result = {{16{es[15]}}, es};
    step();
    flt_done   = 1'b0;
    flt_result = '0;
    check("srv_out_valid", {31'd0, out_valid}, 32'd1);
    check("srv_out_chan", {31'd0, out_chan}, ec);
    check("srv_out_sample", {16'd0, out_sample}, {16'd0, es});
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    vecs[0] = '{1, 16'h8001, 32'h0000_7FF0, 3, 32'hFFFF_8001, 16'h7FF0};
    vecs[1] = '{0, 16'h7FFF, 32'hDEAD_1234, 1, 32'h0000_7FFF, 16'h1234};
    vecs[2] = '{1, 16'h0000, 32'hFFFF_FFFF, 5, 32'h0000_0000, 16'hFFFF};
    vecs[3] = '{0, 16'hFFFF, 32'h0001_8000, 2, 32'hFFFF_FFFF, 16'h8000};

    reset      = 1'b1;
    ch_valid   = '0;
    ch_sample  = '0;
    flt_done   = 1'b0;
    flt_result = '0;
    out_ready  = 1'b0;
    step();
    step();
    reset = 1'b0;
    check("rst_ch_ready", {30'd0, ch_ready}, 32'd3);
    check("rst_flt_start", {31'd0, flt_start}, 32'd0);
    check("rst_flt_chan", {31'd0, flt_chan}, 32'd0);
    check("rst_flt_dataa", flt_dataa, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_chan", {31'd0, out_chan}, 32'd0);
    check("rst_out_sample", {16'd0, out_sample}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err_timeout}, 32'd0);

    // Single transactions: fixed latency, sign extension, result truncation.
    foreach (vecs[v]) begin
      offer(vecs[v].chan, vecs[v].sample);
      step();
      check("tv_start_latency", {31'd0, flt_start}, 32'd1);
      check("tv_flt_chan", {31'd0, flt_chan}, vecs[v].chan);
      check("tv_flt_dataa", flt_dataa, vecs[v].exp_dataa);
      check("tv_busy", {31'd0, busy}, 32'd1);
      for (int k = 0; k < vecs[v].dly; k++) step();
      check("tv_start_pulse", {31'd0, flt_start}, 32'd0);
      check("tv_no_early_out", {31'd0, out_valid}, 32'd0);
      flt_done   = 1'b1;
      flt_result = vecs[v].result;
      step();
      flt_done   = 1'b0;
      flt_result = '0;
      check("tv_out_valid", {31'd0, out_valid}, 32'd1);
      check("tv_out_chan", {31'd0, out_chan}, vecs[v].chan);
      check("tv_out_sample", {16'd0, out_sample}, {16'd0, vecs[v].exp_out});
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("tv_out_drop", {31'd0, out_valid}, 32'd0);
      check("tv_idle", {31'd0, busy}, 32'd0);
    end

    // Reset in the middle of WAIT, then a late done.
    offer(0, 16'h1234);
    step();
    check("rw_dataa", flt_dataa, 32'h0000_1234);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rw_out_valid", {31'd0, out_valid}, 32'd0);
    check("rw_busy", {31'd0, busy}, 32'd0);
    check("rw_ch_ready", {30'd0, ch_ready}, 32'd3);
    check("rw_dataa_clr", flt_dataa, 32'd0);
    flt_done   = 1'b1;
    flt_result = 32'h0000_5555;
    step();
    flt_done   = 1'b0;
    flt_result = '0;
    check("rw_late_out", {31'd0, out_valid}, 32'd0);
    check("rw_late_busy", {31'd0, busy}, 32'd0);
    step();
    check("rw_late_out2", {31'd0, out_valid}, 32'd0);
    check("rw_no_start", {31'd0, flt_start}, 32'd0);

    // Round robin: both channels pending, twice.
    ch_valid  = 2'b11;
    ch_sample = {16'h0020, 16'h0010};
    step();
    ch_valid = 2'b00;
    serve(0, 16'h0010);
    serve(1, 16'h0020);
    ch_valid  = 2'b11;
    ch_sample = {16'h0040, 16'h0030};
    step();
    ch_valid = 2'b00;
    serve(0, 16'h0030);
    serve(1, 16'h0040);

    // Backpressure on the output while ch1 is pending.
    ch_valid  = 2'b11;
    ch_sample = {16'h0002, 16'h0001};
    step();
    ch_valid = 2'b00;
    wait_start();
    check("bp_chan", {31'd0, flt_chan}, 32'd0);
    step();
    flt_done   = 1'b1;
    flt_result = 32'h1234_ABCD;
    step();
    flt_done   = 1'b0;
    flt_result = '0;
    for (int k = 0; k < 10; k++) begin
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_sample", {16'd0, out_sample}, 32'h0000_ABCD);
      check("bp_out_chan", {31'd0, out_chan}, 32'd0);
      check("bp_no_start", {31'd0, flt_start}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_released", {31'd0, out_valid}, 32'd0);
    serve(1, 16'h0002);

    // Watchdog: engine never answers ch0; ch1 proceeds afterwards.
    ch_valid  = 2'b11;
    ch_sample = {16'h0200, 16'h0100};
    step();
    ch_valid = 2'b00;
    wait_start();
    check("to_chan", {31'd0, flt_chan}, 32'd0);
    for (int k = 1; k <= 8; k++) step();
    check("to_err_early", {31'd0, err_timeout}, 32'd0);
    check("to_busy_wait", {31'd0, busy}, 32'd1);
    step();
    check("to_err_set", {31'd0, err_timeout}, 32'd1);
    check("to_idle", {31'd0, busy}, 32'd0);
    check("to_no_out", {31'd0, out_valid}, 32'd0);
    flt_done   = 1'b1;
    flt_result = 32'h0000_7777;
    step();
    flt_done   = 1'b0;
    flt_result = '0;
    check("to_next_start", {31'd0, flt_start}, 32'd1);
    check("to_next_chan", {31'd0, flt_chan}, 32'd1);
    check("to_late_ignored", {31'd0, out_valid}, 32'd0);
    serve(1, 16'h0200);
    check("to_err_sticky", {31'd0, err_timeout}, 32'd1);

    // Second offer to a full holding register waits for the ISSUE cycle.
    offer(1, 16'h0300);
    wait_start();
    check("fi_chan1", {31'd0, flt_chan}, 32'd1);
    ch_valid[0]     = 1'b1;
    ch_sample[15:0] = 16'h0400;
    step();
    ch_sample[15:0] = 16'h0500;
    check("fi_full", {31'd0, ch_ready[0]}, 32'd0);
    step();
    flt_done   = 1'b1;
    flt_result = 32'h0000_0300;
    step();
    flt_done   = 1'b0;
    flt_result = '0;
    check("fi_out_chan1", {31'd0, out_chan}, 32'd1);
    check("fi_out_sample1", {16'd0, out_sample}, 32'h0000_0300);
    check("fi_full_out", {31'd0, ch_ready[0]}, 32'd0);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("fi_full_idle", {31'd0, ch_ready[0]}, 32'd0);
    step();
    check("fi_issue_start", {31'd0, flt_start}, 32'd1);
    check("fi_issue_chan", {31'd0, flt_chan}, 32'd0);
    check("fi_issue_dataa", flt_dataa, 32'h0000_0400);
    check("fi_full_issue", {31'd0, ch_ready[0]}, 32'd0);
    step();
    check("fi_freed", {31'd0, ch_ready[0]}, 32'd1);
    step();
    ch_valid[0] = 1'b0;
    check("fi_refilled", {31'd0, ch_ready[0]}, 32'd0);
    flt_done   = 1'b1;
    flt_result = 32'h0000_0400;
    step();
    flt_done   = 1'b0;
    flt_result = '0;
    check("fi_out_sample0", {16'd0, out_sample}, 32'h0000_0400);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    serve(0, 16'h0500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
